// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_seq_pkg;

    // Default address width when the instantiating core does not override it.
    localparam int ARG_WIDTH = 8;

    // One action per enabled edge, resolved by priority ret > call > jump > increment.
    typedef enum logic [1:0] {
        ACT_INC  = 2'd0,
        ACT_JUMP = 2'd1,
        ACT_CALL = 2'd2,
        ACT_RET  = 2'd3
    } pc_act_e;

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO: register array plus fill pointer; reset clears only the pointer.
module pc_stack
    import pc_seq_pkg::*;
#(
    parameter int ADDR_WIDTH  = ARG_WIDTH,
    parameter int STACK_DEPTH = 8
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           push,
    input  logic                           pop,
    input  logic [ADDR_WIDTH-1:0]          push_data,
    output logic [ADDR_WIDTH-1:0]          top,
    output logic [$clog2(STACK_DEPTH):0]   count,
    output logic                           full,
    output logic                           empty
);

    localparam int PW = $clog2(STACK_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] mem_q [STACK_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_d [STACK_DEPTH];
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic [PW-1:0]         wr_idx;
    logic [PW-1:0]         rd_idx;

    // The pointer's low bits address the next free slot; the top entry sits one below.
    // At count == STACK_DEPTH the low bits wrap to 0, so rd_idx still lands on the last slot.
    assign wr_idx = count_q[PW-1:0];
    assign rd_idx = wr_idx - PW'(1);

    assign top   = mem_q[rd_idx];
    assign count = count_q;
    assign full  = (count_q == CW'(STACK_DEPTH));
    assign empty = (count_q == '0);

    // Next-state for pointer and array; guards keep the LIFO consistent even if misdriven.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (push && !full) begin
            mem_d[wr_idx] = push_data;
            count_d       = count_q + CW'(1);
        end else if (pop && !empty) begin
            count_d = count_q - CW'(1);
        end
    end

    // Entry storage carries no reset; stale contents are unreachable once the pointer clears.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    // Fill pointer with asynchronous clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: stall, reset vector, jump, and call/return via pc_stack.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = ARG_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0,
    parameter int                    STACK_DEPTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  en,
    input  logic                  jump,
    input  logic                  call,
    input  logic                  ret,
    input  logic [ADDR_WIDTH-1:0] target_addr,
    output logic [ADDR_WIDTH-1:0] counter,
    output logic                  stack_empty,
    output logic                  stack_full,
    output logic                  stack_err
);

    localparam int CW = $clog2(STACK_DEPTH) + 1;

    logic [ADDR_WIDTH-1:0] counter_q;
    logic [ADDR_WIDTH-1:0] counter_d;
    logic                  err_q;
    logic                  err_d;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] push_data;
    logic [ADDR_WIDTH-1:0] stk_top;
    logic [CW-1:0]         stk_count;
    logic                  stk_full;
    logic                  stk_empty;
    logic                  can_push;
    logic                  can_pop;
    pc_act_e               act;

    pc_stack #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .top       (stk_top),
        .count     (stk_count),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Return address is the instruction after the call; wraps naturally at the top of the space.
    assign push_data = counter_q + ADDR_WIDTH'(1);
    assign can_push  = (stk_count != CW'(STACK_DEPTH));
    assign can_pop   = (stk_count != '0);

    assign counter     = counter_q;
    assign stack_empty = stk_empty;
    assign stack_full  = stk_full;
    assign stack_err   = err_q;

    // Priority decode; losing requests in the same cycle are simply dropped.
    always_comb begin
        act = ACT_INC;
        if (ret) begin
            act = ACT_RET;
        end else if (call) begin
            act = ACT_CALL;
        end else if (jump) begin
            act = ACT_JUMP;
        end
    end

    // Next counter, stack strobes and sticky error; a stalled cycle changes nothing.
    always_comb begin
        counter_d = counter_q;
        err_d     = err_q;
        push      = 1'b0;
        pop       = 1'b0;
        if (en) begin
            unique case (act)
                ACT_RET: begin
                    if (can_pop) begin
                        counter_d = stk_top;
                        pop       = 1'b1;
                    end else begin
                        counter_d = counter_q + ADDR_WIDTH'(1);
                        err_d     = 1'b1;
                    end
                end
                ACT_CALL: begin
                    counter_d = target_addr;
                    if (can_push) begin
                        push = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ACT_JUMP: counter_d = target_addr;
                default:  counter_d = counter_q + ADDR_WIDTH'(1);
            endcase
        end
    end

    // Counter and sticky error registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            counter_q <= RESET_ADDR;
            err_q     <= 1'b0;
        end else begin
            counter_q <= counter_d;
            err_q     <= err_d;
        end
    end

endmodule
